// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display feeder path.
package seg_disp_pkg;

    localparam int CHAR_W = 8;
    localparam int NUM_DIGITS = 4;
    localparam logic [CHAR_W-1:0] BLANK_DEFAULT = 8'h20;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-rate divider: emits a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while en is low and restarts from zero on clr.
module scroll_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count_reg;
    logic             at_end;

    assign at_end = (count_reg == CNT_W'(TICK_DIV - 1));
    assign tick   = en && at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= at_end ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scroll_buffer.sv
// Message buffer feeding a 4-digit seven-segment driver, scrolling long messages left.
// Define SCROLL_GAP_EN to insert four blank positions before the message wraps.
module seg_scroll_buffer
    import seg_disp_pkg::*;
#(
    parameter int                DEPTH      = 16,
    parameter int                TICK_DIV   = 50_000_000,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = BLANK_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       pause,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHAR_W-1:0]          in_char,
    input  logic                       in_last,
    output logic [CHAR_W-1:0]          char0,
    output logic [CHAR_W-1:0]          char1,
    output logic [CHAR_W-1:0]          char2,
    output logic [CHAR_W-1:0]          char3,
    output logic [$clog2(DEPTH+1)-1:0] msg_len,
    output logic                       scrolling
);

    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int OFF_W = $clog2(DEPTH + 4);
    localparam int EFF_W = $clog2(DEPTH + 5);
    localparam int SUM_W = EFF_W + 1;

    state_t            state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [OFF_W-1:0]  offset_reg;
    logic [CHAR_W-1:0] buf_mem [DEPTH];
    logic [CHAR_W-1:0] char_reg [NUM_DIGITS];
    logic [CHAR_W-1:0] char_next [NUM_DIGITS];

    logic [EFF_W-1:0]  eff_len;
    logic              scroll_mode;
    logic              ready_c;
    logic              accept;
    logic              tick;

    always_comb begin
        eff_len = EFF_W'(len_reg);
`ifdef SCROLL_GAP_EN
        if (len_reg > LEN_W'(NUM_DIGITS)) begin
            eff_len = EFF_W'(len_reg) + EFF_W'(NUM_DIGITS);
        end
`endif
    end

    assign scroll_mode = (state_reg == RUN) && (eff_len > EFF_W'(NUM_DIGITS));
    assign ready_c     = (state_reg == LOAD) && !clear && (len_reg < LEN_W'(DEPTH));
    assign accept      = in_valid && ready_c;

    scroll_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear || (state_reg != RUN)),
        .en   (scroll_mode && !pause),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= LOAD;
            len_reg    <= '0;
            offset_reg <= '0;
        end else if (clear) begin
            state_reg  <= LOAD;
            len_reg    <= '0;
            offset_reg <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (accept) begin
                        len_reg <= len_reg + 1'b1;
                        if (in_last || (len_reg + 1'b1 == LEN_W'(DEPTH))) begin
                            state_reg  <= RUN;
                            offset_reg <= '0;
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        offset_reg <= (EFF_W'(offset_reg) + EFF_W'(1) == eff_len)
                                      ? '0 : offset_reg + 1'b1;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so the entries carry no reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (accept && (len_reg == LEN_W'(gi))) begin
                buf_mem[gi] <= in_char;
            end
        end
    end

    // Digit gi shows message position (offset+gi) mod L; offset < L so one subtract wraps it.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_win
        logic [SUM_W-1:0]  pos;
        logic [CHAR_W-1:0] sel;

        always_comb begin
            pos = SUM_W'(offset_reg) + SUM_W'(gi);
            if (scroll_mode && (pos >= SUM_W'(eff_len))) begin
                pos = pos - SUM_W'(eff_len);
            end
            sel = BLANK_CHAR;
            for (int j = 0; j < DEPTH; j++) begin
                if ((pos == SUM_W'(j)) && (pos < SUM_W'(len_reg))) begin
                    sel = buf_mem[j];
                end
            end
        end

        assign char_next[NUM_DIGITS-1-gi] = sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                char_reg[k] <= BLANK_CHAR;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                char_reg[k] <= char_next[k];
            end
        end
    end

    assign char0     = char_reg[0];
    assign char1     = char_reg[1];
    assign char2     = char_reg[2];
    assign char3     = char_reg[3];
    assign msg_len   = len_reg;
    assign in_ready  = ready_c;
    assign scrolling = scroll_mode;

endmodule
